ir_tx_scheduler: RTL and testbench

IR_TX_SCHEDULER -- requirements
Module: ir_tx_scheduler

---
 rtl/ir_pkg.sv | 25 ++
 rtl/ir_frame_fifo.sv | 64 ++++++
 rtl/ir_tx_scheduler.sv | 131 +++++++++++++
 tb/tb_ir_tx_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared IR definitions: sequencer state encoding, the queued frame type and
// NEC protocol timing shared by the IR transmit blocks.
package ir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] cmd;
  } ir_frame_t;

  // NEC carrier-envelope timing in microseconds, plus the system clock rate.
  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned NEC_LEAD_MARK_US  = 9000;
  localparam int unsigned NEC_LEAD_SPACE_US = 4500;
  localparam int unsigned NEC_BIT_MARK_US   = 562;
  localparam int unsigned NEC_ZERO_SPACE_US = 562;
  localparam int unsigned NEC_ONE_SPACE_US  = 1687;

endpackage

// File: rtl/ir_frame_fifo.sv
// Frame queue between the requester arbiter and the transmit sequencer.
// Power-of-two depth; pointers wrap naturally at their width.
module ir_frame_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [15:0]              push_data,
  input  logic                     pop,
  output logic [15:0]              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import ir_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];
  assign count = cnt_q;

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) rd_d = rd_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/ir_tx_scheduler.sv
// Two-requester round-robin front end feeding a frame FIFO, and a sequencer
// that hands one frame at a time to the NEC transmitter with a busy timeout.
module ir_tx_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                          iCLK_50,
  input  logic                          iRST,
  input  logic [1:0]                    iREQ_VALID,
  input  logic [7:0]                    iREQ_ADDR0,
  input  logic [7:0]                    iREQ_ADDR1,
  input  logic [7:0]                    iREQ_CMD0,
  input  logic [7:0]                    iREQ_CMD1,
  output logic [1:0]                    oREQ_READY,
  input  logic                          iTX_BUSY,
  output logic [7:0]                    oADDRESS,
  output logic [7:0]                    oCOMMAND,
  output logic                          oSEND,
  output logic [$clog2(FIFO_DEPTH):0]   oCOUNT,
  output logic                          oERR
);
  import ir_pkg::*;

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  seq_state_e    state_q, state_d;
  logic          rr_q, rr_d;
  logic          send_q, send_d;
  logic          err_q, err_d;
  logic [7:0]    addr_q, addr_d, cmd_q, cmd_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [1:0]    gnt, ready;
  logic          push, pop, full, empty;
  ir_frame_t     push_frame, head_frame;

  ir_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (iCLK_50),
    .rst       (iRST),
    .push      (push),
    .push_data (push_frame),
    .pop       (pop),
    .head      (head_frame),
    .full      (full),
    .empty     (empty),
    .count     (oCOUNT)
  );

  // Grant only goes to a valid requester, so ready already implies valid.
  always_comb begin
    case (iREQ_VALID)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    ready      = (!full && !iRST) ? gnt : 2'b00;
    push       = |ready;
    push_frame = ready[1] ? '{addr: iREQ_ADDR1, cmd: iREQ_CMD1}
                          : '{addr: iREQ_ADDR0, cmd: iREQ_CMD0};
    rr_d       = push ? ~rr_q : rr_q;
  end

  // The frame is latched on the way into ISSUE so oSEND and the frame
  // appear together; ISSUE then retires the head entry.
  always_comb begin
    state_d = state_q;
    send_d  = 1'b0;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !iTX_BUSY) begin
          state_d = ST_ISSUE;
          send_d  = 1'b1;
          addr_d  = head_frame.addr;
          cmd_d   = head_frame.cmd;
        end
      end
      ST_ISSUE: begin
        pop     = 1'b1;
        tmo_d   = TW'(1);
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (iTX_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q >= TW'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!iTX_BUSY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      send_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      send_q  <= send_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      tmo_q   <= tmo_d;
    end
  end

  assign oREQ_READY = ready;
  assign oSEND      = send_q;
  assign oERR       = err_q;
  assign oADDRESS   = addr_q;
  assign oCOMMAND   = cmd_q;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Scenario bench for ir_tx_scheduler: requester queues feed the DUT, a simple
// transmitter busy model reacts to oSEND, and issued frames are scoreboarded.
module tb_ir_tx_scheduler;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       iRST = 1'b1;
  logic [1:0] iREQ_VALID = 2'b00;
  logic [7:0] iREQ_ADDR0 = 8'h00, iREQ_ADDR1 = 8'h00;
  logic [7:0] iREQ_CMD0 = 8'h00, iREQ_CMD1 = 8'h00;
  logic [1:0] oREQ_READY;
  logic       iTX_BUSY;
  logic [7:0] oADDRESS, oCOMMAND;
  logic       oSEND, oERR;
  logic [2:0] oCOUNT;

  logic busy_force = 1'b0, busy_model = 1'b0, model_en = 1'b0;
  int   hold_len = 10, bhold = 0, cyc = 0;
  int   checks = 0, errors = 0;

  logic [15:0] src0[$], src1[$], acc_q[$], obs_q[$], exp_q[$];
  int          send_cyc[$];

  assign iTX_BUSY = busy_force | busy_model;

  always #5 clk = ~clk;

  ir_tx_scheduler #(.FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
    .iCLK_50    (clk),
    .iRST       (iRST),
    .iREQ_VALID (iREQ_VALID),
    .iREQ_ADDR0 (iREQ_ADDR0),
    .iREQ_ADDR1 (iREQ_ADDR1),
    .iREQ_CMD0  (iREQ_CMD0),
    .iREQ_CMD1  (iREQ_CMD1),
    .oREQ_READY (oREQ_READY),
    .iTX_BUSY   (iTX_BUSY),
    .oADDRESS   (oADDRESS),
    .oCOMMAND   (oCOMMAND),
    .oSEND      (oSEND),
    .oCOUNT     (oCOUNT),
    .oERR       (oERR)
  );

  // One clock: present queue heads, log handshakes before the edge, then
  // at the falling edge log oSEND and advance the transmitter busy model.
  task automatic step();
    logic [15:0] d;
    iREQ_VALID = {src1.size() != 0, src0.size() != 0};
    iREQ_ADDR0 = (src0.size() != 0) ? src0[0][15:8] : 8'h00;
    iREQ_CMD0  = (src0.size() != 0) ? src0[0][7:0]  : 8'h00;
    iREQ_ADDR1 = (src1.size() != 0) ? src1[0][15:8] : 8'h00;
    iREQ_CMD1  = (src1.size() != 0) ? src1[0][7:0]  : 8'h00;
    #1;
    if (iREQ_VALID[0] && oREQ_READY[0]) begin
      d = src0.pop_front();
      acc_q.push_back(d);
    end
    if (iREQ_VALID[1] && oREQ_READY[1]) begin
      d = src1.pop_front();
      acc_q.push_back(d);
    end
    @(negedge clk);
    cyc++;
    if (oSEND === 1'b1) begin
      obs_q.push_back({oADDRESS, oCOMMAND});
      send_cyc.push_back(cyc);
      if (model_en) bhold = hold_len;
    end
    if (bhold > 0) begin
      busy_model = 1'b1;
      bhold--;
    end else begin
      busy_model = 1'b0;
    end
  endtask

  task automatic wait_sends(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && obs_q.size() < n; i++) step();
    ok = (obs_q.size() >= n);
  endtask

  task automatic do_reset();
    src0.delete(); src1.delete(); acc_q.delete();
    obs_q.delete(); exp_q.delete(); send_cyc.delete();
    busy_force = 1'b0; model_en = 1'b0; bhold = 0; busy_model = 1'b0;
    iRST = 1'b1;
    step(); step();
    iRST = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    src0.push_back(16'hAAAA);
    step(); step();
    checks++; if (oREQ_READY !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", oREQ_READY); end
    checks++; if (oSEND !== 1'b0) begin errors++; $display("FAIL reset_send: got %b expected 0", oSEND); end
    checks++; if (oCOUNT !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", oCOUNT); end
    checks++; if (oERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", oERR); end
    checks++; if ({oADDRESS, oCOMMAND} !== 16'h0000) begin errors++; $display("FAIL reset_frame: got %h expected 0000", {oADDRESS, oCOMMAND}); end
    checks++; if (acc_q.size() != 0) begin errors++; $display("FAIL reset_accept: got %0d accepts expected 0", acc_q.size()); end
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    model_en = 1'b1; hold_len = 10;
    src0.push_back(16'h5A13);
    wait_sends(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_send: got no oSEND expected one within 20 cycles"); end
    checks++; if (obs_q.size() != 0 && obs_q[0] !== 16'h5A13) begin errors++; $display("FAIL single_frame: got %h expected 5a13", obs_q[0]); end
    step();
    checks++; if (oSEND !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b expected 0 one cycle after send", oSEND); end
    checks++; if ({oADDRESS, oCOMMAND} !== 16'h5A13) begin errors++; $display("FAIL single_hold: got %h expected 5a13", {oADDRESS, oCOMMAND}); end
    repeat (15) step();
    checks++; if (obs_q.size() != 1 || oCOUNT !== 3'd0) begin errors++; $display("FAIL single_quiet: got %0d sends count %0d expected 1 and 0", obs_q.size(), oCOUNT); end
    src0.push_back(16'h0102);
    wait_sends(2, 6, ok);
    checks++; if (!ok || obs_q[1] !== 16'h0102) begin errors++; $display("FAIL single_idle_return: got %0d sends expected second frame 0102 promptly", obs_q.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    model_en = 1'b1; hold_len = 2;
    src0.push_back(16'hA001); src0.push_back(16'hA102);
    src1.push_back(16'hB010); src1.push_back(16'hB120);
    exp_q = '{16'hA001, 16'hB010, 16'hA102, 16'hB120};
    wait_sends(4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_sends: got %0d sends expected 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rr_accept[%0d]: got %h expected %h", i, (i < acc_q.size()) ? acc_q[i] : 16'hxxxx, exp_q[i]);
      end
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rr_send[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    for (int i = 1; i < send_cyc.size(); i++) begin
      checks++;
      if (send_cyc[i] - send_cyc[i-1] != 4) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 4", i, send_cyc[i] - send_cyc[i-1]); end
    end
  endtask

  task automatic test_full();
    bit ok;
    do_reset();
    busy_force = 1'b1; model_en = 1'b1; hold_len = 2;
    src0 = '{16'hC000, 16'hC001, 16'hC002};
    src1 = '{16'hD000, 16'hD001};
    exp_q = '{16'hC000, 16'hD000, 16'hC001, 16'hD001, 16'hC002};
    repeat (10) step();
    checks++; if (oCOUNT !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", oCOUNT); end
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL full_accepts: got %0d expected 4", acc_q.size()); end
    checks++; if (oREQ_READY !== 2'b00) begin errors++; $display("FAIL full_ready: got %b expected 00", oREQ_READY); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL full_busy_send: got %0d sends expected 0", obs_q.size()); end
    busy_force = 1'b0;
    wait_sends(1, 10, ok);
    checks++; if (!ok || oREQ_READY !== 2'b00) begin errors++; $display("FAIL full_pop_ready: got ok=%0d ready=%b expected ok=1 ready=00", ok, oREQ_READY); end
    step();
    checks++; if (oREQ_READY !== 2'b01) begin errors++; $display("FAIL full_after_pop_ready: got %b expected 01", oREQ_READY); end
    step();
    checks++; if (acc_q.size() != 5) begin errors++; $display("FAIL full_fifth_accept: got %0d expected 5", acc_q.size()); end
    wait_sends(5, 100, ok);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL full_send[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    model_en = 1'b0;
    src0 = '{16'hE1E2, 16'hE3E4};
    wait_sends(1, 20, ok);
    checks++; if (!ok || oERR !== 1'b0) begin errors++; $display("FAIL tmo_first: got ok=%0d err=%b expected ok=1 err=0", ok, oERR); end
    repeat (TMO - 1) step();
    checks++; if (oERR !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0 at cycle %0d", oERR, TMO - 1); end
    step();
    checks++; if (oERR !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b expected 1 at cycle %0d", oERR, TMO); end
    wait_sends(2, 20, ok);
    checks++; if (!ok || obs_q[1] !== 16'hE3E4) begin errors++; $display("FAIL tmo_next: got %0d sends expected second frame e3e4", obs_q.size()); end
    repeat (TMO + 4) step();
    checks++; if (oERR !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", oERR); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    model_en = 1'b1; hold_len = 10;
    src0 = '{16'h1F00, 16'h1F01, 16'h1F02, 16'h1F03};
    wait_sends(1, 20, ok);
    repeat (3) step();
    checks++; if (!ok || oCOUNT !== 3'd3 || iTX_BUSY !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: got count %0d busy %b expected 3 and 1", oCOUNT, iTX_BUSY); end
    iRST = 1'b1;
    obs_q.delete();
    step();
    iRST = 1'b0;
    checks++; if (oCOUNT !== 3'd0) begin errors++; $display("FAIL rst_mid_count: got %0d expected 0", oCOUNT); end
    repeat (20) step();
    checks++; if (obs_q.size() != 0 || oCOUNT !== 3'd0) begin errors++; $display("FAIL rst_mid_quiet: got %0d sends count %0d expected 0 and 0", obs_q.size(), oCOUNT); end
    src0.push_back(16'h7788);
    wait_sends(1, 10, ok);
    checks++; if (!ok || obs_q[0] !== 16'h7788) begin errors++; $display("FAIL rst_mid_new: got %0d sends expected frame 7788", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    busy_force = 1'b1; model_en = 1'b1; hold_len = 2;
    src0 = '{16'h3031, 16'h3233};
    exp_q = '{16'h3031, 16'h3233, 16'h3435};
    repeat (4) step();
    checks++; if (oCOUNT !== 3'd2) begin errors++; $display("FAIL b2b_setup: got count %0d expected 2", oCOUNT); end
    busy_force = 1'b0;
    step();
    checks++; if (oSEND !== 1'b1) begin errors++; $display("FAIL b2b_issue: got oSEND %b expected 1", oSEND); end
    src1.push_back(16'h3435);
    step();
    checks++; if (oCOUNT !== 3'd2 || acc_q.size() != 3) begin errors++; $display("FAIL b2b_count: got count %0d accepts %0d expected 2 and 3", oCOUNT, acc_q.size()); end
    wait_sends(3, 60, ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_send[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
